// File: rtl/frame_sync_decoder.sv
// frame_sync_decoder: rebuilds column/row position, line/frame strobes and the
// NTSC/PAL format from an active-low hsn/fsn pair. A lock FSM qualifies the
// sync so downstream logic only trusts position once timing is stable.
module frame_sync_decoder #(
    parameter int unsigned LINE_COLS   = 458,
    parameter int unsigned HSYNC_COLS  = 29,
    parameter int unsigned COL_TOL     = 2,
    parameter int unsigned LINES_NTSC  = 258,
    parameter int unsigned LINES_PAL   = 311,
    parameter int unsigned VSYNC_ROWS  = 8,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned MISS_MAX    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsn,
    input  logic       fsn,
    output logic [8:0] col,
    output logic [8:0] row,
    output logic       line_start,
    output logic       frame_start,
    output logic       format,
    output logic       locked,
    output logic       sync_err
);
    localparam int unsigned CW = 9;
    localparam int unsigned LW = CW + 1;
    localparam int unsigned GW = $clog2(LOCK_FRAMES + 2);
    localparam int unsigned MW = $clog2(MISS_MAX + 2);

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [LW-1:0] LEN_MIN    = LW'(LINE_COLS - COL_TOL);
    localparam logic [LW-1:0] LEN_MAX    = LW'(LINE_COLS + COL_TOL);
    localparam logic [CW-1:0] HS_MIN     = CW'(HSYNC_COLS - COL_TOL);
    localparam logic [CW-1:0] HS_MAX     = CW'(HSYNC_COLS + COL_TOL);
    localparam logic [CW-1:0] VS_ROWS    = CW'(VSYNC_ROWS);
    localparam logic [LW-1:0] NTSC_LINES = LW'(LINES_NTSC);
    localparam logic [LW-1:0] PAL_LINES  = LW'(LINES_PAL);
    localparam logic [GW-1:0] GOOD_LOCK  = GW'(LOCK_FRAMES);
    localparam logic [MW-1:0] MISS_DROP  = MW'(MISS_MAX);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

    state_t        state_q;
    logic [GW-1:0] good_q;
    logic [MW-1:0] miss_q;
    logic          format_q, locked_q, exempt_q;

    logic          hs_q, fs_ls_q, frame_err_q;
    logic          line_start_q, frame_start_q, sync_err_q;
    logic [CW-1:0] col_q, row_q, hw_q, vs_q;

    logic          fs_ls_d, frame_err_d;
    logic [CW-1:0] col_d, row_d, hw_d, vs_d;

    logic          ls_c, rise_c, fs_c;
    logic [LW-1:0] line_len_c, frame_len_c;
    logic          len_err_c, tmo_err_c, width_err_c, vs_err_c, cnt_err_c;
    logic          line_err_c, err_c, verdict_c, cand_pal_c, count_ok_c, good_c;
    logic [GW-1:0] good_inc_c;
    logic [MW-1:0] miss_inc_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Edge detection, position counters, timing checks and frame verdict.
    always_comb begin
        ls_c   = hs_q & ~hsn;
        rise_c = ~hs_q & hsn;
        fs_c   = ls_c & ~fsn & fs_ls_q;

        col_d      = ls_c ? '0 : sat_inc(col_q);
        line_len_c = {1'b0, col_q} + LW'(1);
        len_err_c  = ls_c & ~exempt_q & ((line_len_c < LEN_MIN) | (line_len_c > LEN_MAX));
        tmo_err_c  = ~ls_c & (col_q == (CNT_MAX - CW'(1)));

        hw_d = hw_q;
        if (!hsn) begin
            hw_d = hs_q ? CW'(1) : sat_inc(hw_q);
        end
        width_err_c = rise_c & ((hw_q < HS_MIN) | (hw_q > HS_MAX));

        vs_d = vs_q;
        if (ls_c && !fsn) begin
            vs_d = fs_c ? CW'(1) : sat_inc(vs_q);
        end
        vs_err_c = ls_c & fsn & ~fs_ls_q & (vs_q != VS_ROWS);
        fs_ls_d  = ls_c ? fsn : fs_ls_q;

        row_d = row_q;
        if (fs_c) begin
            row_d = '0;
        end else if (ls_c) begin
            row_d = sat_inc(row_q);
        end

        frame_len_c = {1'b0, row_q} + LW'(1);
        cand_pal_c  = (frame_len_c == PAL_LINES);
        count_ok_c  = cand_pal_c | (frame_len_c == NTSC_LINES);
        verdict_c   = fs_c & (state_q != ST_SEARCH);
        cnt_err_c   = verdict_c & ~count_ok_c;
        line_err_c  = len_err_c | width_err_c | tmo_err_c | vs_err_c;
        err_c       = line_err_c | cnt_err_c;
        // An error on the frame_start clock belongs to the closing frame.
        good_c      = count_ok_c & ~frame_err_q & ~line_err_c;
        frame_err_d = fs_c ? 1'b0 : (frame_err_q | err_c);

        good_inc_c = (cand_pal_c == format_q) ? good_q + GW'(1) : GW'(1);
        miss_inc_c = miss_q + MW'(1);
    end

    // Datapath registers and output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q          <= 1'b1;
            fs_ls_q       <= 1'b1;
            col_q         <= '0;
            row_q         <= '0;
            hw_q          <= '0;
            vs_q          <= '0;
            frame_err_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            hs_q          <= hsn;
            fs_ls_q       <= fs_ls_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hw_q          <= hw_d;
            vs_q          <= vs_d;
            frame_err_q   <= frame_err_d;
            line_start_q  <= ls_c;
            frame_start_q <= fs_c;
            sync_err_q    <= err_c;
        end
    end

    // Lock FSM: SEARCH -> VERIFY -> LOCKED, driven by per-frame verdicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SEARCH;
            good_q   <= '0;
            miss_q   <= '0;
            format_q <= 1'b0;
            locked_q <= 1'b0;
            exempt_q <= 1'b1;
        end else begin
            locked_q <= (state_q == ST_LOCKED);
            if (ls_c) begin
                exempt_q <= 1'b0;
            end
            if (fs_c) begin
                unique case (state_q)
                    ST_SEARCH: begin
                        state_q <= ST_VERIFY;
                        good_q  <= '0;
                        miss_q  <= '0;
                    end
                    ST_VERIFY: begin
                        if (good_c) begin
                            format_q <= cand_pal_c;
                            good_q   <= good_inc_c;
                            if (good_inc_c >= GOOD_LOCK) begin
                                state_q <= ST_LOCKED;
                            end
                        end else begin
                            state_q  <= ST_SEARCH;
                            exempt_q <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (good_c) begin
                            format_q <= cand_pal_c;
                            miss_q   <= '0;
                            if (cand_pal_c != format_q) begin
                                state_q <= ST_VERIFY;
                                good_q  <= GW'(1);
                            end
                        end else if (miss_inc_c >= MISS_DROP) begin
                            state_q  <= ST_SEARCH;
                            exempt_q <= 1'b1;
                        end else begin
                            miss_q <= miss_inc_c;
                        end
                    end
                    default: state_q <= ST_SEARCH;
                endcase
            end
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign format      = format_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_frame_sync_decoder.sv
// Scoreboard bench for frame_sync_decoder: stimulus pushes the expected
// per-frame_start record, a negedge monitor pops and compares it.
module tb_frame_sync_decoder;
    // Shrunk timing keeps whole frames short.
    localparam int unsigned L   = 40;
    localparam int unsigned HS  = 6;
    localparam int unsigned TOL = 2;
    localparam int unsigned N   = 12;
    localparam int unsigned P   = 15;
    localparam int unsigned V   = 3;

    logic       clk = 1'b0;
    logic       reset, hsn, fsn;
    logic [8:0] col, row;
    logic       line_start, frame_start, format, locked, sync_err;

    always #5 clk = ~clk;

    frame_sync_decoder #(
        .LINE_COLS(L), .HSYNC_COLS(HS), .COL_TOL(TOL), .LINES_NTSC(N),
        .LINES_PAL(P), .VSYNC_ROWS(V), .LOCK_FRAMES(2), .MISS_MAX(2)
    ) dut (
        .clk(clk), .reset(reset), .hsn(hsn), .fsn(fsn),
        .col(col), .row(row), .line_start(line_start), .frame_start(frame_start),
        .format(format), .locked(locked), .sync_err(sync_err)
    );

    typedef struct {
        int lines;   // -1: partial frame, not compared
        int errs;
        int lock;
        int fmt;
        int maxcol;  // -1: not compared
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tot_errs = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_fs(input int lines, input int errs, input int lock,
                           input int fmt, input int maxcol);
        exp_t e;
        e.lines = lines; e.errs = errs; e.lock = lock; e.fmt = fmt; e.maxcol = maxcol;
        exp_q.push_back(e);
    endtask

    task automatic send_line(input int cols, input bit fs_low);
        hsn = 1'b0;
        fsn = fs_low ? 1'b0 : 1'b1;
        tick(HS);
        hsn = 1'b1;
        tick(cols - HS);
    endtask

    task automatic send_frame(input int nlines, input int long_idx, input int long_cols);
        for (int i = 0; i < nlines; i++) begin
            send_line((i == long_idx) ? long_cols : L, i < V);
        end
    endtask

    // Monitor: pops one expected record per frame_start.
    int seg_errs   = 0;
    int seg_maxcol = 0;
    int last_row   = 0;
    int pend_lock  = 0;
    bit lock_pend  = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            seg_errs   = 0;
            seg_maxcol = 0;
            last_row   = 0;
            lock_pend  = 1'b0;
        end else begin
            if (lock_pend) begin
                chk("locked_after_fs", int'(locked), pend_lock);
                lock_pend = 1'b0;
            end
            if (sync_err) begin
                seg_errs++;
                tot_errs++;
            end
            if (frame_start) begin
                chk("fs_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.lines >= 0) chk("frame_lines", last_row + 1, e.lines);
                    chk("frame_errs", seg_errs, e.errs);
                    chk("frame_format", int'(format), e.fmt);
                    chk("fs_row_zero", int'(row), 0);
                    chk("fs_col_zero", int'(col), 0);
                    if (e.maxcol >= 0) chk("frame_max_col", seg_maxcol, e.maxcol);
                    pend_lock = e.lock;
                    lock_pend = 1'b1;
                end
                seg_errs   = 0;
                seg_maxcol = 0;
            end else if (int'(col) > seg_maxcol) begin
                seg_maxcol = int'(col);
            end
            last_row = int'(row);
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_col"},         int'(col), 0);
        chk({tag, "_row"},         int'(row), 0);
        chk({tag, "_line_start"},  int'(line_start), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_format"},      int'(format), 0);
        chk({tag, "_locked"},      int'(locked), 0);
        chk({tag, "_sync_err"},    int'(sync_err), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n_ls;
        int errs0;
        reset = 1'b1;
        hsn   = 1'b1;
        fsn   = 1'b1;
        tick(3);
        chk_reset_values("por");
        reset = 1'b0;
        tick(10);

        // NTSC lock, tolerance and lock loss.
        push_fs(-1, 0, 0, 0, -1);    send_frame(N, -1, L);
        push_fs(N, 0, 0, 0, L - 1);  send_frame(N, -1, L);
        push_fs(N, 0, 1, 0, L - 1);  send_frame(N, 4, L + 2);
        push_fs(N, 0, 1, 0, L + 1);  send_frame(N, 4, L + 3);
        push_fs(N, 1, 1, 0, L + 2);  send_frame(N, 4, L + 3);
        push_fs(N, 1, 0, 0, L + 2);  send_frame(N, -1, L);
        // Reacquire, then switch to PAL.
        push_fs(N, 0, 0, 0, L - 1);  send_frame(N, -1, L);
        push_fs(N, 0, 0, 0, L - 1);  send_frame(N, -1, L);
        push_fs(N, 0, 1, 0, L - 1);  send_frame(N, -1, L);
        push_fs(N, 0, 1, 0, L - 1);  send_frame(P, -1, L);
        push_fs(P, 0, 0, 1, L - 1);  send_frame(P, -1, L);
        push_fs(P, 0, 1, 1, L - 1);

        // Partial PAL frame, then reset mid-frame at row 5, col 19.
        for (int i = 0; i < 5; i++) send_line(L, i < V);
        hsn = 1'b0;
        fsn = 1'b1;
        tick(HS);
        hsn = 1'b1;
        tick(14);
        chk("pre_rst_row", int'(row), 5);
        chk("pre_rst_col", int'(col), 19);
        chk("pre_rst_locked", int'(locked), 1);
        reset = 1'b1;
        tick(1);
        chk_reset_values("mid_rst");
        tick(1);
        reset = 1'b0;
        n_ls = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (line_start) n_ls++;
        end
        chk("no_ls_after_reset", n_ls, 0);

        // PAL acquisition from reset.
        push_fs(-1, 0, 0, 0, -1);    send_frame(P, -1, L);
        push_fs(P, 0, 0, 1, L - 1);  send_frame(P, -1, L);
        push_fs(P, 0, 1, 1, L - 1);  send_frame(P, -1, L);

        // Stuck hsync: timeout, saturation, width error at the rise.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(5);
        errs0 = tot_errs;
        hsn = 1'b0;
        tick(600);
        chk("stuck_col_sat", int'(col), 511);
        chk("stuck_timeout_errs", tot_errs - errs0, 1);
        hsn = 1'b1;
        tick(5);
        chk("stuck_col_hold", int'(col), 511);
        chk("stuck_total_errs", tot_errs - errs0, 2);

        chk("pending_frames", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
